// File: rtl/frame_plotter_pkg.sv
// Shared game constants: default frame geometry, the byte type used for
// screen coordinates, and the color width shared by renderers and framebuffer.
package frame_plotter_pkg;
  localparam int GAME_XMAX = 160;
  localparam int GAME_YMAX = 120;
  localparam int COLOR_W   = 3;

  typedef logic [7:0] ubyte;
endpackage

// File: rtl/pixel_delay_line.sv
// pixel_delay_line: DEPTH-stage shift register carrying {valid, x, y} so the
// framebuffer write strobe and address line up with renderer read data.
// Ports:
//   clk, resetn        clock, synchronous active-low reset (clears every stage)
//   i_valid/i_x/i_y    request-side strobe and coordinates
//   o_valid/o_x/o_y    the same, DEPTH cycles later
module pixel_delay_line
  import frame_plotter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_valid,
  input  ubyte       i_x,
  input  logic [6:0] i_y,
  output logic       o_valid,
  output ubyte       o_x,
  output logic [6:0] o_y
);

  logic       r_valid [DEPTH];
  ubyte       r_x     [DEPTH];
  logic [6:0] r_y     [DEPTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_x[i]     <= '0;
        r_y[i]     <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_x[0]     <= i_x;
      r_y[0]     <= i_y;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_x[i]     <= r_x[i-1];
        r_y[i]     <= r_y[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_x     = r_x[DEPTH-1];
  assign o_y     = r_y[DEPTH-1];

endmodule

// File: rtl/frame_plotter.sv
// frame_plotter: raster-scans every pixel of a frame, asks the renderers for
// its color, and writes the returned color into the framebuffer.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   start                frame request pulse (honoured only in IDLE)
//   reqX, reqY           coordinates presented to the renderers
//   pixColor             renderer color, valid READ_LAT cycles after reqX/reqY
//   vgaX, vgaY, vgaColor framebuffer write address and data
//   plot                 framebuffer write enable
//   busy                 high while a frame is in progress
//   frameDone            one-cycle pulse at frame end (renderer moveClk)
//
// state | meaning
// IDLE  | waiting for start; request coordinates parked at (0,0)
// SCAN  | issuing one pixel request per cycle, row-major
// DRAIN | READ_LAT cycles letting the last requests come back
// DONE  | single cycle, frameDone high
module frame_plotter
  import frame_plotter_pkg::*;
#(
  parameter int XMAX     = GAME_XMAX,
  parameter int YMAX     = GAME_YMAX,
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output ubyte               reqX,
  output ubyte               reqY,
  input  logic [COLOR_W-1:0] pixColor,
  output ubyte               vgaX,
  output logic [6:0]         vgaY,
  output logic [COLOR_W-1:0] vgaColor,
  output logic               plot,
  output logic               busy,
  output logic               frameDone
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  ubyte       r_req_x;
  ubyte       r_req_y;
  logic [1:0] r_drain_cnt;
  logic       w_x_last;
  logic       w_y_last;
  logic       w_scan;

  assign w_x_last = (r_req_x == ubyte'(XMAX - 1));
  assign w_y_last = (r_req_y == ubyte'(YMAX - 1));
  assign w_scan   = (r_state == SCAN);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SCAN;
      SCAN:    if (w_x_last && w_y_last) w_next = DRAIN;
      DRAIN:   if (r_drain_cnt == 2'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The drain timer is preloaded throughout SCAN so it already holds
  // READ_LAT-1 on the first DRAIN cycle and hits terminal count on the last.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_req_x     <= '0;
      r_req_y     <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        SCAN: begin
          r_drain_cnt <= 2'(READ_LAT - 1);
          if (w_x_last) begin
            r_req_x <= '0;
            r_req_y <= w_y_last ? '0 : r_req_y + 8'd1;
          end else begin
            r_req_x <= r_req_x + 8'd1;
          end
        end
        DRAIN: begin
          if (r_drain_cnt != 2'd0) r_drain_cnt <= r_drain_cnt - 2'd1;
        end
        default: begin
          r_req_x <= '0;
          r_req_y <= '0;
        end
      endcase
    end
  end

  pixel_delay_line #(
    .DEPTH (READ_LAT)
  ) u_delay (
    .clk     (clk),
    .resetn  (resetn),
    .i_valid (w_scan),
    .i_x     (r_req_x),
    .i_y     (r_req_y[6:0]),
    .o_valid (plot),
    .o_x     (vgaX),
    .o_y     (vgaY)
  );

  assign reqX      = r_req_x;
  assign reqY      = r_req_y;
  assign vgaColor  = pixColor;
  assign busy      = (r_state != IDLE);
  assign frameDone = (r_state == DONE);

endmodule

// File: tb/tb_frame_plotter.sv
module tb_frame_plotter;
  import frame_plotter_pkg::*;

  localparam int NPIX = GAME_XMAX * GAME_YMAX;
  localparam int BIG  = 32'h3fff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       start;
  logic [7:0] reqX  [2];
  logic [7:0] reqY  [2];
  logic [2:0] pix   [2];
  logic [7:0] vgaX  [2];
  logic [6:0] vgaY  [2];
  logic [2:0] vgaC  [2];
  logic       plot  [2];
  logic       busy  [2];
  logic       fdone [2];

  frame_plotter #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .resetn(resetn), .start(start),
    .reqX(reqX[0]), .reqY(reqY[0]), .pixColor(pix[0]),
    .vgaX(vgaX[0]), .vgaY(vgaY[0]), .vgaColor(vgaC[0]),
    .plot(plot[0]), .busy(busy[0]), .frameDone(fdone[0]));

  frame_plotter #(.READ_LAT(3)) u_lat3 (
    .clk(clk), .resetn(resetn), .start(start),
    .reqX(reqX[1]), .reqY(reqY[1]), .pixColor(pix[1]),
    .vgaX(vgaX[1]), .vgaY(vgaY[1]), .vgaColor(vgaC[1]),
    .plot(plot[1]), .busy(busy[1]), .frameDone(fdone[1]));

  // Renderer models: ROMs returning (x+y)%8 with 1- and 3-cycle latency.
  logic [2:0] rom1;
  logic [2:0] rom3 [3];
  always @(posedge clk) begin
    rom1    <= 3'(reqX[0] + reqY[0]);
    rom3[0] <= 3'(reqX[1] + reqY[1]);
    rom3[1] <= rom3[0];
    rom3[2] <= rom3[1];
  end
  assign pix[0] = rom1;
  assign pix[1] = rom3[2];

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } exp_t;

  exp_t sb [2][$];
  int   dq [2][$];
  int   m_start [2];
  int   m_end   [2];
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_bad    = 0;
  bit   armed    = 0;
  bit   end_req  = 0;
  bit   end_done = 0;
  exp_t e;
  exp_t ne;
  bit   exp_fd;
  bit   in_scan;
  int   idx;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input bit ok, input string nm, input int d, input int act, input int expv);
    n_vec++;
    if (!ok) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, expv);
    end
  endtask

  // Monitor and reference model, once per cycle away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        if (sb[d].size() > 0 && sb[d][0].t == cyc) begin
          e = sb[d].pop_front();
          chk(plot[d] == 1'b1, "plot_missing", d, int'(plot[d]), 1);
          chk(int'(vgaX[d]) == e.x, "vgaX", d, int'(vgaX[d]), e.x);
          chk(int'(vgaY[d]) == e.y, "vgaY", d, int'(vgaY[d]), e.y);
          chk(int'(vgaC[d]) == e.c, "vgaColor", d, int'(vgaC[d]), e.c);
        end else begin
          chk(plot[d] == 1'b0, "plot_spurious", d, int'(plot[d]), 0);
        end
        exp_fd = (dq[d].size() > 0 && dq[d][0] == cyc);
        if (exp_fd) void'(dq[d].pop_front());
        chk(fdone[d] == exp_fd, "frameDone", d, int'(fdone[d]), int'(exp_fd));
        chk(busy[d] == (cyc >= m_start[d] && cyc <= m_end[d]), "busy", d,
            int'(busy[d]), int'(cyc >= m_start[d] && cyc <= m_end[d]));
        idx     = cyc - m_start[d];
        in_scan = (cyc >= m_start[d]) && (idx < NPIX);
        chk(int'(reqX[d]) == (in_scan ? idx % GAME_XMAX : 0), "reqX", d,
            int'(reqX[d]), in_scan ? idx % GAME_XMAX : 0);
        chk(int'(reqY[d]) == (in_scan ? idx / GAME_XMAX : 0), "reqY", d,
            int'(reqY[d]), in_scan ? idx / GAME_XMAX : 0);
      end
    end
    if (end_req && !end_done) begin
      for (int d = 0; d < 2; d++) begin
        chk(sb[d].size() == 0, "writes_outstanding", d, sb[d].size(), 0);
        chk(dq[d].size() == 0, "done_outstanding", d, dq[d].size(), 0);
      end
      end_done = 1;
    end
    // Inputs sampled by the coming rising edge.
    if (!resetn) begin
      for (int d = 0; d < 2; d++) begin
        sb[d].delete();
        dq[d].delete();
        m_start[d] = BIG;
        m_end[d]   = -1;
      end
      armed = 1;
    end else if (start) begin
      for (int d = 0; d < 2; d++) begin
        if (cyc > m_end[d]) begin
          m_start[d] = cyc + 1;
          m_end[d]   = cyc + NPIX + lat_of(d) + 1;
          for (int k = 0; k < NPIX; k++) begin
            ne.x = k % GAME_XMAX;
            ne.y = k / GAME_XMAX;
            ne.c = (ne.x + ne.y) % 8;
            ne.t = cyc + 1 + lat_of(d) + k;
            sb[d].push_back(ne);
          end
          dq[d].push_back(m_end[d]);
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t0;
  int t1;

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    tick(); tick();
    start = 1'b1;
    tick(); tick();
    start  = 1'b0;
    resetn = 1'b1;
    repeat ($urandom_range(2, 10)) tick();

    // Single frame, with ignored start pulses mid-SCAN and in DONE.
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(500, 4000)) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    while (cyc < t0 + NPIX + 2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < t0 + NPIX + 15) tick();

    // start held high: back-to-back frames, then reset at pixel 5000.
    t1 = cyc;
    start = 1'b1;
    while (cyc < t1 + NPIX + 4 + 5001) tick();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    start  = 1'b0;
    repeat ($urandom_range(3, 20)) tick();

    // Restart after abort must begin again at (0,0).
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (5) tick();
    end_req = 1'b1;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_plotter.md
FRAME_PLOTTER -- requirements
Module: frame_plotter

Interface
REQ-001 The block SHALL have parameter XMAX, default 160, meaning frame width in pixels.
REQ-002 The block SHALL have parameter YMAX, default 120, meaning frame height in pixels.
REQ-003 The block SHALL have parameter READ_LAT, default 1, legal range 1..3, meaning cycles from request coordinates to valid pixColor.
REQ-004 The block SHALL have port clk, input, 1 bit, system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit, synchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, frame request pulse.
REQ-007 The block SHALL have port reqX, output, 8 bits, column presented to the renderers.
REQ-008 The block SHALL have port reqY, output, 8 bits, row presented to the renderers.
REQ-009 The block SHALL have port pixColor, input, 3 bits, renderer color, valid READ_LAT cycles after reqX/reqY.
REQ-010 The block SHALL have port vgaX, output, 8 bits, framebuffer write column.
REQ-011 The block SHALL have port vgaY, output, 7 bits, framebuffer write row.
REQ-012 The block SHALL have port vgaColor, output, 3 bits, framebuffer write data.
REQ-013 The block SHALL have port plot, output, 1 bit, framebuffer write enable.
REQ-014 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-015 The block SHALL have port frameDone, output, 1 bit, one-cycle pulse at frame end; renderers use it as moveClk.

Function
REQ-016 The FSM SHALL have the states IDLE, SCAN, DRAIN and DONE.
REQ-017 In IDLE, start=1 SHALL move the FSM to SCAN on the next edge, with reqX=0 and reqY=0.
REQ-018 In SCAN, reqX SHALL increment every cycle; when reqX=XMAX-1, reqX SHALL wrap to 0 and reqY SHALL increment.
REQ-019 When SCAN issues (XMAX-1, YMAX-1), the FSM SHALL go to DRAIN on the next edge, and reqX/reqY SHALL return to 0.
REQ-020 DRAIN SHALL last exactly READ_LAT cycles, then go to DONE.
REQ-021 DONE SHALL last one cycle, assert frameDone, and then go to IDLE.
REQ-022 A valid bit and the coordinates SHALL be delayed through a READ_LAT-deep shift register, so that plot, vgaX and vgaY align with pixColor.
REQ-023 vgaColor SHALL equal pixColor in the cycle plot is high, passed through combinationally.
REQ-024 plot SHALL be high for exactly XMAX*YMAX cycles per frame, contiguous, with the first write at (0,0) and the last at (XMAX-1,YMAX-1).
REQ-025 A frame SHALL span XMAX*YMAX+READ_LAT+1 cycles from the first SCAN cycle to the end of DONE.
REQ-026 busy SHALL be high in SCAN, DRAIN and DONE, and low in IDLE.
REQ-027 start SHALL be ignored in SCAN, DRAIN and DONE; start asserted in DONE SHALL NOT queue a frame.
REQ-028 start held high continuously SHALL produce back-to-back frames separated by one IDLE cycle.
REQ-029 vgaY SHALL be the low 7 bits of the delayed reqY; reqY SHALL never exceed YMAX-1.
REQ-030 The counters SHALL be 8 bits wide; no intermediate value SHALL exceed XMAX-1 or YMAX-1.

Reset
REQ-031 With resetn=0 at an edge, the FSM SHALL go to IDLE.
REQ-032 With resetn=0 at an edge, reqX, reqY, vgaX and vgaY SHALL become 0.
REQ-033 With resetn=0 at an edge, plot, busy and frameDone SHALL become 0, and all delay-line valid bits SHALL clear.
REQ-034 A reset mid-frame SHALL abort the frame with no further plot pulses and no frameDone.
REQ-035 start sampled in the same cycle as resetn=0 SHALL be ignored.

Structure
REQ-036 XMAX, YMAX, the ubyte type and the color width SHALL come from the shared game constants header.
REQ-037 The FSM state encodings SHALL be local to this module.
REQ-038 One sub-module SHALL be used: pixel_delay_line, a parameterised READ_LAT-deep shift register carrying {valid, x, y}.

Verification
REQ-039 Reset, then one start pulse at cycle 0 (READ_LAT=1) -> first plot at cycle 2 with vgaX=0, vgaY=0; 19200 plot cycles; frameDone exactly once, at cycle 19202; busy low at cycle 19203.
REQ-040 With the renderer modelled as a 1-cycle ROM returning (x+y)%8 -> every write has vgaColor=(vgaX+vgaY)%8; no address is written twice or missed.
REQ-041 Row wrap -> the write after (159,0) is (0,1); the final write is (159,119).
REQ-042 start pulsed mid-SCAN and in DONE -> no second frame; the plot count stays 19200.
REQ-043 resetn=0 at pixel 5000 -> plot is 0 from the next cycle; no frameDone; a following start begins again at (0,0).
REQ-044 READ_LAT=3 with a 3-cycle ROM model -> colors stay aligned; frameDone arrives 2 cycles later than in the READ_LAT=1 case.
